// File: rtl/seg_scan_capture.sv
// Seven-segment scan capture: watches a multiplexed 4-digit display bus
// and recovers the hex value, decimal point and blank/unknown status per digit.
module seg_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        dp,
  output logic [15:0] digits,
  output logic [3:0]  dps,
  output logic [3:0]  blank,
  output logic [3:0]  unknown,
  output logic        frame_done,
  output logic        valid,
  output logic        err_multi
);

  localparam logic [15:0] LP_STABLE = 16'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HOLD
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [15:0] w_cnt_inc;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp;
  logic [3:0]  r_pan;
  logic [6:0]  r_pseg;
  logic        r_pdp;
  logic [3:0]  r_cap;
  logic [3:0]  w_cap_base;
  logic [3:0]  w_cap_nxt;
  logic [15:0] r_digits;
  logic [3:0]  r_dps;
  logic [3:0]  r_blank;
  logic [3:0]  r_unknown;
  logic        r_frame_done;
  logic        r_valid;
  logic        r_err;
  logic        w_one;
  logic        w_multi;
  logic        w_same;
  logic        w_accept;
  logic        w_frame;
  logic        w_blank;
  logic        w_hit;
  logic [3:0]  w_hex;
  logic [1:0]  w_k;

  assign w_one   = (r_an == 4'b1110) || (r_an == 4'b1101) ||
                   (r_an == 4'b1011) || (r_an == 4'b0111);
  assign w_multi = !w_one && (r_an != 4'hF);
  assign w_same  = ({r_an, r_seg, r_dp} == {r_pan, r_pseg, r_pdp});
  assign w_blank = (r_seg == 7'h7F);

  assign w_cnt_inc = (r_cnt >= LP_STABLE) ? r_cnt : r_cnt + 16'd1;

  always_comb begin
    w_k = 2'd0;
    case (r_an)
      4'b1101: w_k = 2'd1;
      4'b1011: w_k = 2'd2;
      4'b0111: w_k = 2'd3;
      default: w_k = 2'd0;
    endcase
  end

  always_comb begin
    w_hex = 4'h0;
    w_hit = 1'b1;
    case (r_seg)
      7'h40:   w_hex = 4'h0;
      7'h79:   w_hex = 4'h1;
      7'h24:   w_hex = 4'h2;
      7'h30:   w_hex = 4'h3;
      7'h19:   w_hex = 4'h4;
      7'h12:   w_hex = 4'h5;
      7'h02:   w_hex = 4'h6;
      7'h78:   w_hex = 4'h7;
      7'h00:   w_hex = 4'h8;
      7'h10:   w_hex = 4'h9;
      7'h08:   w_hex = 4'hA;
      7'h03:   w_hex = 4'hB;
      7'h46:   w_hex = 4'hC;
      7'h21:   w_hex = 4'hD;
      7'h06:   w_hex = 4'hE;
      7'h0E:   w_hex = 4'hF;
      default: w_hit = 1'b0;
    endcase
  end

  // HOLD with a changed sample falls through to the IDLE decision
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    if (w_multi) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (r_state == TRACK) begin
      if (w_same) begin
        w_cnt_nxt = w_cnt_inc;
        if (w_cnt_inc == LP_STABLE) begin
          w_accept    = 1'b1;
          w_state_nxt = HOLD;
        end
      end else if (w_one) begin
        w_cnt_nxt = 16'd1;
      end else begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    end else if (r_state == HOLD && w_same) begin
      w_state_nxt = HOLD;
    end else if (w_one) begin
      w_state_nxt = TRACK;
      w_cnt_nxt   = 16'd1;
    end else begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end
  end

  assign w_cap_base = (r_cap == 4'hF) ? 4'h0 : r_cap;
  assign w_cap_nxt  = w_cap_base | (w_accept ? ~r_an : 4'h0);
  assign w_frame    = (w_cap_nxt == 4'hF);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an    <= 4'hF;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
      r_pan   <= 4'hF;
      r_pseg  <= 7'h7F;
      r_pdp   <= 1'b1;
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_an    <= an;
      r_seg   <= seg;
      r_dp    <= dp;
      r_pan   <= r_an;
      r_pseg  <= r_seg;
      r_pdp   <= r_dp;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap        <= '0;
      r_digits     <= '0;
      r_dps        <= '0;
      r_blank      <= '0;
      r_unknown    <= '0;
      r_frame_done <= 1'b0;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_cap        <= w_cap_nxt;
      r_frame_done <= w_frame;
      if (w_frame) r_valid <= 1'b1;
      if (w_multi) r_err <= 1'b1;
      if (w_accept) begin
        r_dps[w_k]     <= ~r_dp;
        r_blank[w_k]   <= w_blank;
        r_unknown[w_k] <= ~w_hit & ~w_blank;
        if (w_hit) r_digits[{w_k, 2'b00} +: 4] <= w_hex;
      end
    end
  end

  assign digits     = r_digits;
  assign dps        = r_dps;
  assign blank      = r_blank;
  assign unknown    = r_unknown;
  assign frame_done = r_frame_done;
  assign valid      = r_valid;
  assign err_multi  = r_err;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Randomized scoreboard bench for seg_scan_capture with a hold-level
// reference model that predicts every captured frame.
module tb_seg_scan_capture;

  localparam int STABLE = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] digits;
  logic [3:0]  dps;
  logic [3:0]  blank;
  logic [3:0]  unknown;
  logic        frame_done;
  logic        valid;
  logic        err_multi;

  seg_scan_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk),
    .rst(rst),
    .an(an),
    .seg(seg),
    .dp(dp),
    .digits(digits),
    .dps(dps),
    .blank(blank),
    .unknown(unknown),
    .frame_done(frame_done),
    .valid(valid),
    .err_multi(err_multi)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  p;
    logic [3:0]  b;
    logic [3:0]  u;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int m_frames = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                             7'h46, 7'h21, 7'h06, 7'h0E};

  logic [15:0] m_dig;
  logic [3:0]  m_p, m_b, m_u, m_cap;
  logic        m_valid, m_err;
  logic [11:0] m_prev;
  int          m_run;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (glyph[i] == s) return i;
    return -1;
  endfunction

  task automatic model_accept(input logic [3:0] a, input logic [6:0] s,
                              input logic d);
    int k;
    int idx;
    k = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) k = i;
    idx = decode(s);
    m_p[k] = ~d;
    m_b[k] = (s == 7'h7F);
    m_u[k] = (idx < 0) && (s != 7'h7F);
    if (idx >= 0) m_dig[k*4 +: 4] = 4'(idx);
    m_cap[k] = 1'b1;
    if (m_cap == 4'hF) begin
      exp_q.push_back('{d: m_dig, p: m_p, b: m_b, u: m_u});
      m_cap = 4'h0;
      m_valid = 1'b1;
      m_frames++;
    end
  endtask

  // A digit is taken once its run of identical samples first reaches STABLE
  task automatic hold(input logic [3:0] a, input logic [6:0] s,
                      input logic d, input int n);
    logic [11:0] v;
    int pre;
    v = {a, s, d};
    pre = (v == m_prev) ? m_run : 0;
    m_run = pre + n;
    m_prev = v;
    if ($countones(~a) >= 2) m_err = 1'b1;
    if ($countones(~a) == 1 && pre < STABLE && m_run >= STABLE)
      model_accept(a, s, d);
    an = a;
    seg = s;
    dp = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    an = 4'hF;
    seg = 7'h7F;
    dp = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_dig = '0;
    m_p = '0;
    m_b = '0;
    m_u = '0;
    m_cap = '0;
    m_valid = 1'b0;
    m_err = 1'b0;
    m_prev = {4'hF, 7'h7F, 1'b1};
    m_run = 0;
  endtask

  task automatic checkpoint(input string tag);
    hold(4'hF, 7'h7F, 1'b1, 4);
    check({tag, ".digits"}, 32'(digits), 32'(m_dig));
    check({tag, ".dps"}, 32'(dps), 32'(m_p));
    check({tag, ".blank"}, 32'(blank), 32'(m_b));
    check({tag, ".unknown"}, 32'(unknown), 32'(m_u));
    check({tag, ".valid"}, 32'(valid), 32'(m_valid));
    check({tag, ".err_multi"}, 32'(err_multi), 32'(m_err));
    check({tag, ".pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && frame_done === 1'b1) begin
      frame_t e;
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_done: pulse with no frame expected");
      end else begin
        e = exp_q.pop_front();
        check("frame.digits", 32'(digits), 32'(e.d));
        check("frame.dps", 32'(dps), 32'(e.p));
        check("frame.blank", 32'(blank), 32'(e.b));
        check("frame.unknown", 32'(unknown), 32'(e.u));
        check("frame.valid", 32'(valid), 32'd1);
      end
    end
  end

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [6:0] s;
    logic [3:0] a;
    int v;
    rst = 1'b1;
    an = 4'hF;
    seg = 7'h7F;
    dp = 1'b1;
    @(negedge clk);
    do_reset();
    check("rst.digits", 32'(digits), 32'h0);
    check("rst.dps", 32'(dps), 32'h0);
    check("rst.blank", 32'(blank), 32'h0);
    check("rst.unknown", 32'(unknown), 32'h0);
    check("rst.frame_done", 32'(frame_done), 32'h0);
    check("rst.valid", 32'(valid), 32'h0);
    check("rst.err_multi", 32'(err_multi), 32'h0);

    for (int r = 0; r < 2; r++) begin
      hold(4'b0111, glyph[1], 1'b1, 1000);
      hold(4'b1011, glyph[2], 1'b1, 1000);
      hold(4'b1101, glyph[3], 1'b1, 1000);
      hold(4'b1110, glyph[4], 1'b1, 1000);
    end
    checkpoint("scan1234");
    check("scan1234.digits_lit", 32'(digits), 32'h1234);

    hold(4'b1110, 7'h40, 1'b1, STABLE - 1);
    hold(4'b1101, glyph[5], 1'b1, STABLE + 2);
    checkpoint("short_hold");

    hold(4'b0111, glyph[7], 1'b1, STABLE + 3);
    hold(4'b1011, 7'h7F, 1'b1, STABLE + 3);
    hold(4'b1101, glyph[9], 1'b0, STABLE + 3);
    hold(4'b1110, 7'h55, 1'b1, STABLE + 3);
    checkpoint("blank_unknown");
    check("blank_unknown.blank_lit", 32'(blank), 32'h4);
    check("blank_unknown.unknown_lit", 32'(unknown), 32'h1);

    hold(4'b0111, glyph[10], 1'b1, STABLE + 4);
    hold(4'b1100, glyph[10], 1'b1, 1);
    hold(4'b1011, glyph[11], 1'b1, STABLE + 4);
    hold(4'b1101, glyph[12], 1'b1, STABLE + 4);
    hold(4'b1110, glyph[13], 1'b1, STABLE + 4);
    hold(4'b0111, glyph[14], 1'b1, STABLE + 4);
    checkpoint("multi");

    for (int f = 0; f < 25; f++) begin
      for (int k = 3; k >= 0; k--) begin
        a = 4'hF;
        a[($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : k] = 1'b0;
        v = $urandom_range(0, 9);
        if (v == 0) s = 7'h7F;
        else if (v == 1) begin
          do s = 7'($urandom_range(0, 127));
          while (decode(s) >= 0 || s == 7'h7F);
        end else s = glyph[$urandom_range(0, 15)];
        hold(a, s, 1'($urandom_range(0, 1)),
             $urandom_range(STABLE - 3, STABLE + 12));
        if ($urandom_range(0, 14) == 0)
          hold(4'b0101, s, 1'b1, $urandom_range(1, 3));
        if ($urandom_range(0, 7) == 0)
          hold(4'hF, 7'h7F, 1'b1, $urandom_range(1, 5));
      end
    end
    checkpoint("random");

    do_reset();
    hold(4'b0111, glyph[6], 1'b1, STABLE + 2);
    hold(4'b1011, glyph[7], 1'b1, STABLE + 2);
    hold(4'b1101, glyph[8], 1'b1, STABLE + 2);
    hold(4'hF, 7'h7F, 1'b1, 4);
    check("partial.pending", 32'(exp_q.size()), 32'd0);
    do_reset();
    check("partial.after_rst_digits", 32'(digits), 32'h0);
    hold(4'b0111, glyph[0], 1'b1, STABLE + 5);
    hold(4'b1011, glyph[0], 1'b1, STABLE + 5);
    hold(4'b1101, glyph[15], 1'b0, STABLE + 5);
    hold(4'b1110, glyph[0], 1'b1, STABLE + 5);
    checkpoint("frame00F0");
    check("frame00F0.digits_lit", 32'(digits), 32'h00F0);
    check("frame00F0.dps_lit", 32'(dps), 32'h2);

    check("pulse_count", 32'(pulses), 32'(m_frames));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
